seq_bin_to_bcd: RTL and testbench

- Multi-cycle shift-and-add-3 (double-dabble) converter.
- Sits directly downstream of the signed multiplier: it consumes the 14-bit product magnitude and its sign bit, and produces packed BCD plus sign for the display scan logic.
- It replaces the combinational converter with a start/done handshake so that display data changes only on completed conversions.

---
 rtl/seq_bin_to_bcd.sv | 127 ++++++++++++
 tb/tb_seq_bin_to_bcd.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_bin_to_bcd.sv
// Sequential double-dabble converter: turns an unsigned magnitude plus its
// sign into packed BCD over BIN_W cycles behind a start/done handshake.
// Results appear only at completion, so the display logic never sees a
// partially converted value.
module seq_bin_to_bcd #(
  parameter int BIN_W       = 14,
  parameter int DIGITS      = 5,
  parameter int SHOW_DIGITS = 3
) (
  input  logic                  sys_clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  input  logic                  sign_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  sign_out,
  output logic                  ovf_disp
);

  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int BCD_W = 4 * DIGITS;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [BIN_W-1:0]   bin_sr;
  logic [BCD_W-1:0]   scratch;
  logic               sign_hold;

  logic               load;
  logic               shift_en;
  logic               finish;
  logic [BCD_W-1:0]   adj;
  logic [BCD_W-1:0]   shifted;

  // Add 3 to every digit that is 5 or more, all digits in parallel
  function automatic logic [BCD_W-1:0] add3_digits(input logic [BCD_W-1:0] s);
    logic [BCD_W-1:0] r;
    r = s;
    for (int i = 0; i < DIGITS; i++) begin
      if (s[4*i +: 4] >= 4'd5) r[4*i +: 4] = s[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  // True when any digit the display cannot show is nonzero
  function automatic logic high_nonzero(input logic [BCD_W-1:0] b);
    logic r;
    r = 1'b0;
    for (int i = SHOW_DIGITS; i < DIGITS; i++) begin
      r = r | (|b[4*i +: 4]);
    end
    return r;
  endfunction

  assign adj     = add3_digits(scratch);
  assign shifted = {adj[BCD_W-2:0], bin_sr[BIN_W-1]};
  assign busy    = (state == SHIFT);

  // State register
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and datapath strobes; busy starts are ignored by construction
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    shift_en  = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        shift_en = 1'b1;
        if (cnt == CNT_W'(1)) begin
          finish    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, shift loop and result registers
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      bin_sr    <= '0;
      scratch   <= '0;
      sign_hold <= 1'b0;
      done      <= 1'b0;
      bcd_out   <= '0;
      sign_out  <= 1'b0;
      ovf_disp  <= 1'b0;
    end else begin
      done <= finish;
      if (load) begin
        bin_sr    <= bin_in;
        sign_hold <= sign_in;
        scratch   <= '0;
        cnt       <= CNT_W'(BIN_W);
      end else if (shift_en) begin
        scratch <= shifted;
        bin_sr  <= {bin_sr[BIN_W-2:0], 1'b0};
        cnt     <= cnt - CNT_W'(1);
      end
      if (finish) begin
        bcd_out  <= shifted;
        sign_out <= sign_hold;
        ovf_disp <= high_nonzero(shifted);
      end
    end
  end

endmodule

// File: tb/tb_seq_bin_to_bcd.sv
// Scoreboard bench for seq_bin_to_bcd: expected results are queued when a
// conversion is started and compared when done pulses.
module tb_seq_bin_to_bcd;

  localparam int BIN_W = 14;
  localparam int DIGITS = 5;
  localparam int SHOW_DIGITS = 3;

  logic                sys_clk;
  logic                rst;
  logic                start;
  logic [BIN_W-1:0]    bin_in;
  logic                sign_in;
  logic                busy;
  logic                done;
  logic [4*DIGITS-1:0] bcd_out;
  logic                sign_out;
  logic                ovf_disp;

  typedef struct {
    logic [4*DIGITS-1:0] bcd;
    logic                sgn;
    logic                ovf;
    int                  start_cyc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;

  seq_bin_to_bcd #(
    .BIN_W(BIN_W), .DIGITS(DIGITS), .SHOW_DIGITS(SHOW_DIGITS)
  ) dut (
    .sys_clk (sys_clk),
    .rst     (rst),
    .start   (start),
    .bin_in  (bin_in),
    .sign_in (sign_in),
    .busy    (busy),
    .done    (done),
    .bcd_out (bcd_out),
    .sign_out(sign_out),
    .ovf_disp(ovf_disp)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [4*DIGITS-1:0] to_bcd(input int v);
    logic [4*DIGITS-1:0] r;
    int x;
    x = v;
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Drive a start pulse after an edge; it is sampled at the following edge
  task automatic start_conv(input int v, input logic s, input bit expect_accept);
    exp_t e;
    start   = 1'b1;
    bin_in  = BIN_W'(v);
    sign_in = s;
    if (expect_accept) begin
      e.bcd       = to_bcd(v);
      e.sgn       = s;
      e.ovf       = (v >= 10**SHOW_DIGITS);
      e.start_cyc = cyc + 1;
      sb.push_back(e);
    end
    @(posedge sys_clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input bit scramble);
    int n;
    n = 0;
    while (n < 100) begin
      @(posedge sys_clk); #1;
      if (done) break;
      if (scramble) begin
        bin_in  = BIN_W'($urandom);
        sign_in = 1'($urandom);
      end
      n++;
    end
    if (n >= 100) check("done_timeout", 32'd0, 32'd1);
  endtask

  // Monitor: score completions, done width, busy length and output holding
  logic [4*DIGITS-1:0] last_bcd = '0;
  logic                prev_done = 1'b0;
  int                  bcnt = 0;
  always @(negedge sys_clk) begin
    exp_t e;
    if (rst) begin
      last_bcd = '0;
      bcnt = 0;
    end else if (done) begin
      check("done_width", 32'(prev_done), 32'd0);
      if (sb.size() == 0) begin
        check("spurious_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("bcd_out", 32'(bcd_out), 32'(e.bcd));
        check("sign_out", 32'(sign_out), 32'(e.sgn));
        check("ovf_disp", 32'(ovf_disp), 32'(e.ovf));
        check("latency", 32'(cyc - e.start_cyc), 32'(BIN_W));
        check("busy_len", 32'(bcnt), 32'(BIN_W));
        last_bcd = e.bcd;
      end
      bcnt = 0;
    end else begin
      check("bcd_hold", 32'(bcd_out), 32'(last_bcd));
    end
    if (busy) bcnt++;
    prev_done = done;
  end

  initial begin
    rst = 1'b1;
    start = 1'b0;
    bin_in = '0;
    sign_in = 1'b0;
    repeat (2) @(posedge sys_clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_bcd", 32'(bcd_out), 32'd0);
    check("rst_sign", 32'(sign_out), 32'd0);
    check("rst_ovf", 32'(ovf_disp), 32'd0);
    rst = 1'b0;
    @(posedge sys_clk); #1;

    // Zero input
    start_conv(0, 1'b0, 1'b1);
    check("busy_after_start", 32'(busy), 32'd1);
    wait_done(1'b0);

    // 255 negative
    start_conv(255, 1'b1, 1'b1);
    wait_done(1'b0);

    // Maximum, then back-to-back start in the done cycle
    start_conv(16383, 1'b0, 1'b1);
    wait_done(1'b0);
    start_conv(999, 1'b0, 1'b1);
    wait_done(1'b0);

    // Starts during SHIFT are ignored
    start_conv(1000, 1'b0, 1'b1);
    repeat (2) @(posedge sys_clk);
    #1;
    start_conv(42, 1'b1, 1'b0);
    repeat (9) @(posedge sys_clk);
    #1;
    start_conv(42, 1'b1, 1'b0);
    wait_done(1'b0);
    repeat (20) @(posedge sys_clk);
    #1;

    // Abort by reset mid-conversion
    start_conv(512, 1'b1, 1'b1);
    wait_done(1'b0);
    start_conv(77, 1'b0, 1'b1);
    repeat (5) @(posedge sys_clk);
    #2;
    rst = 1'b1;
    #1;
    check("abort_bcd", 32'(bcd_out), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_sign", 32'(sign_out), 32'd0);
    sb.delete();
    @(posedge sys_clk); #1;
    rst = 1'b0;
    repeat (20) @(posedge sys_clk);
    #1;
    start_conv(77, 1'b0, 1'b1);
    wait_done(1'b0);

    // Inputs toggling during SHIFT have no effect
    start_conv(12345, 1'b1, 1'b1);
    wait_done(1'b1);

    // Sign carried through even for a zero magnitude
    start_conv(0, 1'b1, 1'b1);
    wait_done(1'b0);
    repeat (3) @(posedge sys_clk);
    #1;

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
